// File: rtl/toast_dmem.sv
// toast_dmem: dual-port data memory for the toast core.
//
// Port A is the pipeline MEM-stage side: it reads every cycle (registered data one cycle later) and
// writes byte lanes with no handshake. Port B is the loader/debug side: valid/ready requests with a
// one-cycle registered read response. Reads are write-first per lane with respect to writes
// committed in the same cycle by either port. Addresses above the memory size are out of range:
// writes are dropped and reads return zero. Memory contents survive reset.
//
// Ports:
//   clk_i            sole clock, rising edge
//   rst_i            synchronous active-high reset
//   a_addr_i         port A byte address (word aligned)
//   a_wr_byte_en_i   port A lane write enables, 0 = read-only cycle
//   a_wr_data_i      port A lane-positioned write data
//   a_rd_data_o      port A registered read data
//   a_err_o          port A out-of-range flag, aligned with a_rd_data_o
//   b_valid_i        port B request valid
//   b_ready_o        port B request accept (combinational)
//   b_we_i           port B write (1) / read (0)
//   b_addr_i         port B byte address
//   b_wr_byte_en_i   port B lane write enables
//   b_wr_data_i      port B lane-positioned write data
//   b_rd_valid_o     port B read response strobe, one cycle
//   b_rd_data_o      port B read response data, held between responses

module toast_dmem #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] a_addr_i,
    input  logic [3:0]  a_wr_byte_en_i,
    input  logic [31:0] a_wr_data_i,
    output logic [31:0] a_rd_data_o,
    output logic        a_err_o,
    input  logic        b_valid_i,
    output logic        b_ready_o,
    input  logic        b_we_i,
    input  logic [31:0] b_addr_i,
    input  logic [3:0]  b_wr_byte_en_i,
    input  logic [31:0] b_wr_data_i,
    output logic        b_rd_valid_o,
    output logic [31:0] b_rd_data_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [AW-1:0] a_idx, b_idx;
    logic          a_oor, b_oor;
    logic          same_word;
    logic          a_wr, b_acc, b_wr, b_rd;
    logic [31:0]   a_wr_word, b_wr_word;
    logic [31:0]   a_rd_d, b_rd_d;

    logic [31:0] a_rd_data_q;
    logic        a_err_q;
    logic        b_rd_valid_q;
    logic [31:0] b_rd_data_q;

    // Byte offset bits are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{a_addr_i[1:0], b_addr_i[1:0]};

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int n = 0; n < 4; n++) begin
            if (be[n]) res[8*n +: 8] = new_w[8*n +: 8];
        end
        return res;
    endfunction

    assign a_idx     = a_addr_i[AW+1:2];
    assign b_idx     = b_addr_i[AW+1:2];
    assign a_oor     = |a_addr_i[31:AW+2];
    assign b_oor     = |b_addr_i[31:AW+2];
    assign same_word = (a_addr_i[31:2] == b_addr_i[31:2]);

    // Port B write to the word port A is writing is held off, so the two write ports never
    // collide on one word; the stalled B write retries once port A moves on.
    always_comb begin
        b_ready_o = 1'b1;
        if (rst_i) begin
            b_ready_o = 1'b0;
        end else if (b_valid_i && b_we_i && (|b_wr_byte_en_i) && (|a_wr_byte_en_i) && same_word) begin
            b_ready_o = 1'b0;
        end
    end

    assign a_wr  = !rst_i && !a_oor && (|a_wr_byte_en_i);
    assign b_acc = b_valid_i && b_ready_o;
    assign b_wr  = b_acc && b_we_i && !b_oor && (|b_wr_byte_en_i);
    assign b_rd  = b_acc && !b_we_i;

    assign a_wr_word = merge_lanes(mem_q[a_idx], a_wr_data_i, a_wr_byte_en_i);
    assign b_wr_word = merge_lanes(mem_q[b_idx], b_wr_data_i, b_wr_byte_en_i);

    // Write-first read data: fold in any lane written this cycle to the same word.
    always_comb begin
        a_rd_d = mem_q[a_idx];
        if (a_wr) a_rd_d = a_wr_word;
        if (b_wr && same_word) a_rd_d = merge_lanes(a_rd_d, b_wr_data_i, b_wr_byte_en_i);
        if (a_oor) a_rd_d = 32'h0;

        b_rd_d = mem_q[b_idx];
        if (a_wr && same_word) b_rd_d = merge_lanes(b_rd_d, a_wr_data_i, a_wr_byte_en_i);
        if (b_oor) b_rd_d = 32'h0;
    end

    // Storage is not reset.
    always_ff @(posedge clk_i) begin
        if (a_wr) mem_q[a_idx] <= a_wr_word;
        if (b_wr) mem_q[b_idx] <= b_wr_word;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_rd_data_q  <= 32'h0;
            a_err_q      <= 1'b0;
            b_rd_valid_q <= 1'b0;
            b_rd_data_q  <= 32'h0;
        end else begin
            a_rd_data_q  <= a_rd_d;
            a_err_q      <= a_oor;
            b_rd_valid_q <= b_rd;
            if (b_rd) b_rd_data_q <= b_rd_d;
        end
    end

    // Outputs are forced low while reset is high, which also drops a port B response that was
    // accepted in the cycle just before reset.
    assign a_rd_data_o  = rst_i ? 32'h0 : a_rd_data_q;
    assign a_err_o      = !rst_i && a_err_q;
    assign b_rd_valid_o = !rst_i && b_rd_valid_q;
    assign b_rd_data_o  = rst_i ? 32'h0 : b_rd_data_q;

endmodule

// File: tb/tb_toast_dmem.sv
module tb_toast_dmem;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_addr;
    logic [3:0]  a_be;
    logic [31:0] a_wdata;
    logic [31:0] a_rdata;
    logic        a_err;
    logic        b_valid;
    logic        b_ready;
    logic        b_we;
    logic [31:0] b_addr;
    logic [3:0]  b_be;
    logic [31:0] b_wdata;
    logic        b_rvalid;
    logic [31:0] b_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    toast_dmem #(.DEPTH_WORDS(1024)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .a_addr_i       (a_addr),
        .a_wr_byte_en_i (a_be),
        .a_wr_data_i    (a_wdata),
        .a_rd_data_o    (a_rdata),
        .a_err_o        (a_err),
        .b_valid_i      (b_valid),
        .b_ready_o      (b_ready),
        .b_we_i         (b_we),
        .b_addr_i       (b_addr),
        .b_wr_byte_en_i (b_be),
        .b_wr_data_i    (b_wdata),
        .b_rd_valid_o   (b_rvalid),
        .b_rd_data_o    (b_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_addr  = 32'h0;
        a_be    = 4'h0;
        a_wdata = 32'h0;
        b_valid = 1'b0;
        b_we    = 1'b0;
        b_addr  = 32'h0;
        b_be    = 4'h0;
        b_wdata = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        b_valid = 1'b1;
        step();
        step();
        tests_run++;
        if (a_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_a_rdata: got %h want %h", a_rdata, 32'h0);
        end
        tests_run++;
        if (a_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_a_err: got %b want 0", a_err);
        end
        tests_run++;
        if (b_rvalid !== 1'b0 || b_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_b_resp: got v=%b d=%h want v=0 d=0", b_rvalid, b_rdata);
        end
        tests_run++;
        if (b_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_b_ready: got %b want 0", b_ready);
        end
        b_valid = 1'b0;
        rst = 1'b0;
        #1;
        tests_run++;
        if (b_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_b_ready: got %b want 1", b_ready);
        end
    endtask

    task automatic test_basic_write();
        idle();
        a_addr = 32'h10; a_be = 4'hF; a_wdata = 32'hDEADBEEF;
        step();
        a_be = 4'h0;
        step();
        tests_run++;
        if (a_rdata !== 32'hDEADBEEF || a_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_write: got %h err=%b want deadbeef err=0", a_rdata, a_err);
        end
    endtask

    task automatic test_read_during_write();
        idle();
        a_addr = 32'h20; a_be = 4'hF; a_wdata = 32'h11223344;
        step();
        a_be = 4'b0100; a_wdata = 32'h00AA0000;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 32'h20;
        #1;
        tests_run++;
        if (b_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rdw_b_ready: got %b want 1", b_ready);
        end
        step();
        tests_run++;
        if (a_rdata !== 32'h11AA3344) begin
            tests_failed++;
            $display("FAIL rdw_a_data: got %h want 11aa3344", a_rdata);
        end
        tests_run++;
        if (b_rvalid !== 1'b1 || b_rdata !== 32'h11AA3344) begin
            tests_failed++;
            $display("FAIL rdw_b_data: got v=%b d=%h want v=1 d=11aa3344", b_rvalid, b_rdata);
        end
        a_be = 4'h0; b_valid = 1'b0;
        step();
        tests_run++;
        if (a_rdata !== 32'h11AA3344) begin
            tests_failed++;
            $display("FAIL rdw_mem: got %h want 11aa3344", a_rdata);
        end
    endtask

    task automatic test_conflict();
        idle();
        a_addr = 32'h40; a_be = 4'hF; a_wdata = 32'h11111111;
        b_valid = 1'b1; b_we = 1'b1; b_addr = 32'h40; b_be = 4'b0011; b_wdata = 32'h0000BBBB;
        #1;
        tests_run++;
        if (b_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL conflict_stall: got b_ready=%b want 0", b_ready);
        end
        step();
        a_be = 4'h0; a_addr = 32'h0;
        #1;
        tests_run++;
        if (b_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL conflict_retry: got b_ready=%b want 1", b_ready);
        end
        step();
        b_valid = 1'b0;
        a_addr = 32'h40;
        step();
        tests_run++;
        if (a_rdata !== 32'h1111BBBB) begin
            tests_failed++;
            $display("FAIL conflict_final: got %h want 1111bbbb", a_rdata);
        end
    endtask

    task automatic test_out_of_range();
        idle();
        a_addr = 32'h0; a_be = 4'hF; a_wdata = 32'hCAFEF00D;
        step();
        a_addr = 32'h00001000; a_be = 4'hF; a_wdata = 32'hFFFFFFFF;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 32'h00001000;
        step();
        tests_run++;
        if (a_rdata !== 32'h0 || a_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL oor_a: got %h err=%b want 0 err=1", a_rdata, a_err);
        end
        tests_run++;
        if (b_rvalid !== 1'b1 || b_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL oor_b: got v=%b d=%h want v=1 d=0", b_rvalid, b_rdata);
        end
        idle();
        step();
        tests_run++;
        if (a_rdata !== 32'hCAFEF00D || a_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL oor_word0: got %h err=%b want cafef00d err=0", a_rdata, a_err);
        end
    endtask

    task automatic test_simultaneous_writes();
        idle();
        a_addr = 32'h50; a_be = 4'hF; a_wdata = 32'h50505050;
        b_valid = 1'b1; b_we = 1'b1; b_addr = 32'h54; b_be = 4'hF; b_wdata = 32'h54545454;
        step();
        a_be = 4'h0;
        b_we = 1'b0;
        step();
        tests_run++;
        if (a_rdata !== 32'h50505050) begin
            tests_failed++;
            $display("FAIL simul_a: got %h want 50505050", a_rdata);
        end
        tests_run++;
        if (b_rvalid !== 1'b1 || b_rdata !== 32'h54545454) begin
            tests_failed++;
            $display("FAIL simul_b: got v=%b d=%h want v=1 d=54545454", b_rvalid, b_rdata);
        end
        b_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        idle();
        b_valid = 1'b1; b_we = 1'b1; b_be = 4'hF;
        b_addr = 32'h4; b_wdata = 32'h44444444;
        step();
        b_addr = 32'h8; b_wdata = 32'h88888888;
        step();
        b_we = 1'b0; b_addr = 32'h0;
        step();
        b_addr = 32'h4;
        #1;
        tests_run++;
        if (b_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready: got %b want 1", b_ready);
        end
        tests_run++;
        if (b_rvalid !== 1'b1 || b_rdata !== 32'hCAFEF00D) begin
            tests_failed++;
            $display("FAIL b2b_rd0: got v=%b d=%h want v=1 d=cafef00d", b_rvalid, b_rdata);
        end
        step();
        b_addr = 32'h8;
        tests_run++;
        if (b_rvalid !== 1'b1 || b_rdata !== 32'h44444444) begin
            tests_failed++;
            $display("FAIL b2b_rd1: got v=%b d=%h want v=1 d=44444444", b_rvalid, b_rdata);
        end
        step();
        b_valid = 1'b0;
        tests_run++;
        if (b_rvalid !== 1'b1 || b_rdata !== 32'h88888888) begin
            tests_failed++;
            $display("FAIL b2b_rd2: got v=%b d=%h want v=1 d=88888888", b_rvalid, b_rdata);
        end
        step();
        tests_run++;
        if (b_rvalid !== 1'b0 || b_rdata !== 32'h88888888) begin
            tests_failed++;
            $display("FAIL b2b_hold: got v=%b d=%h want v=0 d=88888888", b_rvalid, b_rdata);
        end
        // Zero byte enables: accepted, no change.
        b_valid = 1'b1; b_we = 1'b1; b_addr = 32'h8; b_be = 4'h0; b_wdata = 32'h0;
        #1;
        tests_run++;
        if (b_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_be_ready: got %b want 1", b_ready);
        end
        step();
        b_valid = 1'b0;
        a_addr = 32'h8;
        step();
        tests_run++;
        if (a_rdata !== 32'h88888888) begin
            tests_failed++;
            $display("FAIL zero_be_noop: got %h want 88888888", a_rdata);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        a_addr = 32'h8; a_be = 4'hF; a_wdata = 32'h00000055;
        step();
        a_be = 4'h0;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 32'h8;
        step();
        // B read accepted on the last edge; reset now asserts, dropping its response.
        rst = 1'b1;
        b_valid = 1'b0;
        a_be = 4'hF; a_wdata = 32'hFFFFFFFF;
        #1;
        tests_run++;
        if (b_rvalid !== 1'b0 || a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: got bv=%b bd=%h ad=%h want 0 0 0",
                     b_rvalid, b_rdata, a_rdata);
        end
        step();
        step();
        tests_run++;
        if (b_rvalid !== 1'b0 || a_rdata !== 32'h0 || a_err !== 1'b0 || b_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_hold: got bv=%b ad=%h err=%b rdy=%b want 0 0 0 0",
                     b_rvalid, a_rdata, a_err, b_ready);
        end
        rst = 1'b0;
        a_be = 4'h0;
        b_valid = 1'b1; b_addr = 32'h8;
        #1;
        tests_run++;
        if (b_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_ready: got %b want 1", b_ready);
        end
        step();
        b_valid = 1'b0;
        tests_run++;
        if (a_rdata !== 32'h00000055) begin
            tests_failed++;
            $display("FAIL rst_mid_a_data: got %h want 00000055", a_rdata);
        end
        tests_run++;
        if (b_rvalid !== 1'b1 || b_rdata !== 32'h00000055) begin
            tests_failed++;
            $display("FAIL rst_mid_b_data: got v=%b d=%h want v=1 d=00000055", b_rvalid, b_rdata);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_basic_write();
        test_read_during_write();
        test_conflict();
        test_out_of_range();
        test_simultaneous_writes();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
